// File: rtl/n_io_tile_cfg.sv
// North-edge IO tile: frame-loaded per-channel pad config, input sync/invert, optional output reg.
// Optional input glitch filter is enabled by defining IO_GLITCH_FILTER_EN.
module n_io_tile_cfg #(
  parameter int unsigned NUM_CH          = 16,
  parameter int unsigned MaxFramesPerCol = 8,
  parameter int unsigned FrameBitsPerRow = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FILT_W          = 3
) (
  input  logic                       UserCLK,
  input  logic                       UserRST_N,
  output logic                       UserCLK_o,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_o,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_o,
  input  logic [NUM_CH-1:0]          pad_in,
  output logic [NUM_CH-1:0]          pad_out,
  output logic [NUM_CH-1:0]          pad_oe,
  input  logic [NUM_CH-1:0]          fab_in,
  output logic [NUM_CH-1:0]          fab_out
);

  localparam int unsigned CfgW  = MaxFramesPerCol * FrameBitsPerRow;
  localparam int unsigned SyncN = (SYNC_STAGES == 0) ? 1 : SYNC_STAGES;

  if (4 * NUM_CH > CfgW) begin : g_bad_cfg_size
    $error("n_io_tile_cfg: 4*NUM_CH exceeds config store size");
  end
  if (FILT_W == 0 || SYNC_STAGES > 3) begin : g_bad_param
    $error("n_io_tile_cfg: FILT_W must be nonzero and SYNC_STAGES at most 3");
  end

  assign UserCLK_o     = UserCLK;
  assign FrameData_o   = FrameData;
  assign FrameStrobe_o = FrameStrobe;

  logic [CfgW-1:0] cfg_q, cfg_d;

  always_comb begin
    cfg_d = cfg_q;
    for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
      if (FrameStrobe[f]) cfg_d[f*FrameBitsPerRow +: FrameBitsPerRow] = FrameData;
    end
  end

  logic [NUM_CH-1:0] oe, in_reg, out_reg, inv;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      oe[i]      = cfg_q[4*i];
      in_reg[i]  = cfg_q[4*i+1];
      out_reg[i] = cfg_q[4*i+2];
      inv[i]     = cfg_q[4*i+3];
    end
  end

  // Synchroniser shifts continuously; IN_REG only selects whether its tail is used.
  logic [SyncN-1:0][NUM_CH-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pad_in;
    for (int unsigned k = 1; k < SyncN; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  logic [NUM_CH-1:0] in_src;

`ifdef IO_GLITCH_FILTER_EN
  logic [NUM_CH-1:0]             filt_q, filt_d;
  logic [NUM_CH-1:0][FILT_W-1:0] cnt_q, cnt_d;

  // filt follows sync only after sync has disagreed for 2**FILT_W consecutive edges.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!in_reg[i] || (sync_q[SyncN-1][i] == filt_q[i])) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == {FILT_W{1'b1}}) begin
        filt_d[i] = sync_q[SyncN-1][i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge UserCLK) begin
    if (!UserRST_N) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_src = filt_q;
`else
  assign in_src = sync_q[SyncN-1];
`endif

  logic [NUM_CH-1:0] out_comb;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] oe_q, oe_d;

  // Output registers load only while OUT_REG is set so they hold across a 1->0 switch.
  always_comb begin
    out_comb = (fab_in ^ inv) & oe;
    out_d    = (out_reg & out_comb) | (~out_reg & out_q);
    oe_d     = (out_reg & oe) | (~out_reg & oe_q);
    pad_out  = (out_reg & out_q) | (~out_reg & out_comb);
    pad_oe   = (out_reg & oe_q) | (~out_reg & oe);
    fab_out  = ((in_reg & in_src) | (~in_reg & pad_in)) ^ inv;
  end

  always_ff @(posedge UserCLK) begin
    if (!UserRST_N) begin
      cfg_q  <= '0;
      sync_q <= '0;
      out_q  <= '0;
      oe_q   <= '0;
    end else begin
      cfg_q  <= cfg_d;
      sync_q <= sync_d;
      out_q  <= out_d;
      oe_q   <= oe_d;
    end
  end

endmodule
